// File: rtl/btn_ctrl_pkg.sv
// Shared types and helpers for the multi-channel button input controller.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  // Ceiling log2, never below 1 so every counter has at least one bit.
  function automatic int clog2_f(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce filter and hold/long/repeat FSM.
module btn_channel
  import btn_ctrl_pkg::*;
#(
  parameter int MIN_PULSE_WIDTH   = 25000,
  parameter int LONG_PRESS_CYCLES = 12500000,
  parameter int REPEAT_CYCLES     = 2500000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic i_clk,
  input  logic reset_n,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_btn,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DB_W   = clog2_f(MIN_PULSE_WIDTH);
  localparam int HOLD_W = clog2_f(LONG_PRESS_CYCLES);
  localparam int REP_W  = clog2_f(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(MIN_PULSE_WIDTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - MIN_PULSE_WIDTH - 3);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
  // Raw pin level that means "released"; the synchroniser resets to it.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  logic              sync1_q, sync2_q;
  logic              pressed_s;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              btn_q, btn_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;
  hold_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

  assign pressed_s = sync2_q ^ IDLE_LVL;

  // Debounce and hold FSM next-state; an accepted release overrides long/repeat.
  always_comb begin
    db_cnt_d   = '0;
    btn_d      = btn_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;

    if (pressed_s != btn_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_d     = pressed_s;
        press_d   = pressed_s;
        release_d = ~pressed_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_d = '0;
    end

    if (release_d) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d    = HELD;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            long_d    = 1'b1;
            state_d   = LONG;
            rep_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        LONG: begin
          // Phase keeps running with repeat disabled so re-enabling stays aligned.
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            repeat_d  = i_repeat_en;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= IDLE_LVL;
      sync2_q    <= IDLE_LVL;
      db_cnt_q   <= '0;
      btn_q      <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      btn_q      <= btn_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign o_btn     = btn_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// N-channel front-panel button controller: independent debounced channels with events.
module btn_input_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int NUM_BTN           = 2,
  parameter int MIN_PULSE_WIDTH   = 25000,
  parameter int LONG_PRESS_CYCLES = 12500000,
  parameter int REPEAT_CYCLES     = 2500000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic               i_clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic [NUM_BTN-1:0] i_repeat_en,
  output logic [NUM_BTN-1:0] o_btn,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_long,
  output logic [NUM_BTN-1:0] o_repeat
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .MIN_PULSE_WIDTH  (MIN_PULSE_WIDTH),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_ch (
      .i_clk      (i_clk),
      .reset_n    (reset_n),
      .i_btn      (i_btn[g]),
      .i_repeat_en(i_repeat_en[g]),
      .o_btn      (o_btn[g]),
      .o_press    (o_press[g]),
      .o_release  (o_release[g]),
      .o_long     (o_long[g]),
      .o_repeat   (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Self-checking bench for btn_input_ctrl: segment table, corner sequences, random stimulus.
module tb_btn_input_ctrl;
  import btn_ctrl_pkg::*;

  localparam int NB  = 2;
  localparam int MPW = 4;
  localparam int LP  = 20;
  localparam int RP  = 8;

  logic          i_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NB-1:0] i_btn = 2'b11;
  logic [NB-1:0] i_repeat_en = 2'b00;
  logic [NB-1:0] o_btn, o_press, o_release, o_long, o_repeat;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  btn_input_ctrl #(
    .NUM_BTN(NB), .MIN_PULSE_WIDTH(MPW), .LONG_PRESS_CYCLES(LP),
    .REPEAT_CYCLES(RP), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(i_clk), .reset_n(reset_n), .i_btn(i_btn), .i_repeat_en(i_repeat_en),
    .o_btn(o_btn), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  // Reference model: pin history, stability run length, and event timestamps.
  logic          h1_m[NB], h2_m[NB], lvl_m[NB];
  int            run_m[NB], press_cyc_m[NB], long_cyc_m[NB];
  int            cyc = 0;
  logic [NB-1:0] exp_btn, exp_press, exp_release, exp_long, exp_repeat;
  int            cnt_press, cnt_rel, cnt_long, cnt_rep;

  typedef struct {
    logic [NB-1:0] btn;
    logic [NB-1:0] en;
    int            ncyc;
    logic          exp_btn;
    int            n_press;
    int            n_rel;
    int            n_long;
    int            n_rep;
  } seg_t;
  seg_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      h1_m[c] = 1'b1; h2_m[c] = 1'b1; lvl_m[c] = 1'b0;
      run_m[c] = 0; press_cyc_m[c] = 0; long_cyc_m[c] = -1;
    end
    exp_btn = '0; exp_press = '0; exp_release = '0; exp_long = '0; exp_repeat = '0;
  endtask

  task automatic step();
    @(posedge i_clk);
    cyc++;
    for (int c = 0; c < NB; c++) begin
      logic p;
      p = ~h2_m[c];
      h2_m[c] = h1_m[c];
      h1_m[c] = i_btn[c];
      exp_press[c] = 1'b0; exp_release[c] = 1'b0; exp_long[c] = 1'b0; exp_repeat[c] = 1'b0;
      if (p != lvl_m[c]) begin
        run_m[c]++;
        if (run_m[c] == MPW) begin
          lvl_m[c] = p;
          run_m[c] = 0;
          if (p) exp_press[c] = 1'b1;
          else   exp_release[c] = 1'b1;
        end
      end else begin
        run_m[c] = 0;
      end
      if (exp_press[c]) begin
        press_cyc_m[c] = cyc;
        long_cyc_m[c]  = -1;
      end else if (exp_release[c]) begin
        long_cyc_m[c] = -1;
      end else if (lvl_m[c]) begin
        if (long_cyc_m[c] < 0) begin
          if (cyc - press_cyc_m[c] == LP - MPW - 2) begin
            exp_long[c]   = 1'b1;
            long_cyc_m[c] = cyc;
          end
        end else if (((cyc - long_cyc_m[c]) % RP) == 0 && i_repeat_en[c]) begin
          exp_repeat[c] = 1'b1;
        end
      end
      exp_btn[c] = lvl_m[c];
    end
    #1;
    check("model_btn", 32'(o_btn), 32'(exp_btn));
    check("model_press", 32'(o_press), 32'(exp_press));
    check("model_release", 32'(o_release), 32'(exp_release));
    check("model_long", 32'(o_long), 32'(exp_long));
    check("model_repeat", 32'(o_repeat), 32'(exp_repeat));
    cnt_press += int'(o_press[0]);
    cnt_rel   += int'(o_release[0]);
    cnt_long  += int'(o_long[0]);
    cnt_rep   += int'(o_repeat[0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Long press with repeat, release colliding with a repeat wrap, repeat off, bounce.
    tbl[0] = '{2'b10, 2'b01, 30, 1'b1, 1, 0, 1, 1};
    tbl[1] = '{2'b10, 2'b01, 16, 1'b1, 0, 0, 0, 2};
    tbl[2] = '{2'b11, 2'b01, 10, 1'b0, 0, 1, 0, 0};
    tbl[3] = '{2'b10, 2'b00, 40, 1'b1, 1, 0, 1, 0};
    tbl[4] = '{2'b11, 2'b00, 10, 1'b0, 0, 1, 0, 0};
    tbl[5] = '{2'b10, 2'b00, 3,  1'b0, 0, 0, 0, 0};
    tbl[6] = '{2'b11, 2'b00, 1,  1'b0, 0, 0, 0, 0};
    tbl[7] = '{2'b10, 2'b00, 10, 1'b1, 1, 0, 0, 0};
    tbl[8] = '{2'b11, 2'b00, 10, 1'b0, 0, 1, 0, 0};

    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_btn", 32'(o_btn), 32'd0);
    check("reset_press", 32'(o_press), 32'd0);
    check("reset_release", 32'(o_release), 32'd0);
    check("reset_long", 32'(o_long), 32'd0);
    check("reset_repeat", 32'(o_repeat), 32'd0);
    @(negedge i_clk) reset_n = 1'b1;
    repeat (5) step();

    for (int s = 0; s < 9; s++) begin
      i_btn = tbl[s].btn;
      i_repeat_en = tbl[s].en;
      cnt_press = 0; cnt_rel = 0; cnt_long = 0; cnt_rep = 0;
      repeat (tbl[s].ncyc) step();
      check($sformatf("seg%0d_btn", s), 32'(o_btn[0]), 32'(tbl[s].exp_btn));
      check($sformatf("seg%0d_npress", s), 32'(cnt_press), 32'(tbl[s].n_press));
      check($sformatf("seg%0d_nrelease", s), 32'(cnt_rel), 32'(tbl[s].n_rel));
      check($sformatf("seg%0d_nlong", s), 32'(cnt_long), 32'(tbl[s].n_long));
      check($sformatf("seg%0d_nrepeat", s), 32'(cnt_rep), 32'(tbl[s].n_rep));
    end

    // Clean press latency, then a release accepted exactly at the long threshold.
    i_btn = 2'b10;
    i_repeat_en = 2'b01;
    repeat (5) step();
    check("lat_before", 32'(o_btn[0]), 32'd0);
    step();
    check("lat_press", 32'(o_press[0]), 32'd1);
    check("lat_ch1_quiet", 32'(o_press[1]), 32'd0);
    repeat (8) step();
    i_btn = 2'b11;
    repeat (5) step();
    check("coll_still_held", 32'(o_btn[0]), 32'd1);
    step();
    check("coll_release", 32'(o_release[0]), 32'd1);
    check("coll_no_long", 32'(o_long[0]), 32'd0);
    check("coll_state", 32'(dut.g_ch[0].u_ch.state_q), 32'(IDLE));
    cnt_long = 0;
    repeat (20) step();
    check("coll_no_late_long", 32'(cnt_long), 32'd0);

    // Async reset while channel 0 sits in LONG, button kept held.
    i_btn = 2'b10;
    repeat (6 + 14 + 3) step();
    check("prerst_held", 32'(o_btn[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_btn", 32'(o_btn), 32'd0);
    check("rst_press", 32'(o_press), 32'd0);
    check("rst_release", 32'(o_release), 32'd0);
    check("rst_long", 32'(o_long), 32'd0);
    check("rst_repeat", 32'(o_repeat), 32'd0);
    model_reset();
    repeat (2) @(negedge i_clk);
    reset_n = 1'b1;
    repeat (5) step();
    check("rst_no_early_press", 32'(o_btn[0]), 32'd0);
    step();
    check("rst_repress", 32'(o_press[0]), 32'd1);
    check("rst_ch1_idle", 32'(o_btn[1]), 32'd0);

    // Random pin activity on both channels against the model.
    for (int n = 0; n < 300; n++) begin
      i_btn = NB'($urandom);
      i_repeat_en = NB'($urandom);
      repeat ($urandom_range(1, 40)) step();
    end
    i_btn = 2'b11;
    repeat (20) step();
    check("final_released", 32'(o_btn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
